// File: rtl/dig_scan_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dig_scan_pkg                                                 |
// | Description : Shared definitions for the multiplexed hex display scanner:  |
// |               register offsets, CTRL field layout, CTRL reset value and    |
// |               the hex-to-segment table.                                    |
// | Ports       : none (package)                                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+

`ifndef PERI_ADDR_DIG
`define PERI_ADDR_DIG 32'h4000_0100
`endif

package dig_scan_pkg;

  // Register byte offsets from BASE_ADDR
  localparam logic [31:0] c_data_ofs = 32'h0000_0000;
  localparam logic [31:0] c_ctrl_ofs = 32'h0000_0004;

  // CTRL field positions
  localparam int unsigned c_ctrl_en_bit     = 0;
  localparam int unsigned c_ctrl_lzs_bit    = 1;
  localparam int unsigned c_ctrl_dig_lsb    = 8;
  localparam int unsigned c_ctrl_dp_lsb     = 16;
  localparam int unsigned c_ctrl_bright_lsb = 24;

  // EN=1, all digits enabled, BRIGHT=15, LZS=0, no decimal points
  localparam logic [31:0] c_ctrl_rst   = 32'h0F00_FF01;
  // Only implemented CTRL bits are stored; everything else reads back 0
  localparam logic [31:0] c_ctrl_wmask = 32'h0FFF_FF03;

  // CTRL register viewed as fields (matches the bit positions above)
  typedef struct packed {
    logic [3:0] rsvd_hi;
    logic [3:0] bright;
    logic [7:0] dp_mask;
    logic [7:0] dig_mask;
    logic [5:0] rsvd_lo;
    logic       lzs;
    logic       en;
  } ctrl_t;

  // Segment pattern {a,b,c,d,e,f,g}; the dp bit is appended by the caller.
  function automatic logic [6:0] seg_lut(input logic [3:0] hex);
    logic [6:0] pat;
    case (hex)
      4'h0:    pat = 7'h7E;
      4'h1:    pat = 7'h30;
      4'h2:    pat = 7'h6D;
      4'h3:    pat = 7'h79;
      4'h4:    pat = 7'h33;
      4'h5:    pat = 7'h5B;
      4'h6:    pat = 7'h5F;
      4'h7:    pat = 7'h70;
      4'h8:    pat = 7'h7F;
      4'h9:    pat = 7'h7B;
      4'hA:    pat = 7'h77;
      4'hB:    pat = 7'h1F;
      4'hC:    pat = 7'h4E;
      4'hD:    pat = 7'h3D;
      4'hE:    pat = 7'h4F;
      default: pat = 7'h47;
    endcase
    return pat;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dig_scan_seg_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : seg_decode                                                   |
// | Description : Combinational hex digit to 7-segment pattern decoder.        |
// | Ports       : hex_i [3:0] - hex value                                      |
// |               seg_o [6:0] - segments {a,b,c,d,e,f,g}, active-high          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module seg_decode
  import dig_scan_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  assign seg_o = seg_lut(hex_i);

endmodule

`default_nettype wire

// File: rtl/dig_scan.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dig_scan                                                     |
// | Description : Multiplexed 7-segment hex display scanner with a DATA/CTRL   |
// |               register pair, frame-synchronous DATA update, PWM dimming,   |
// |               per-digit enable/dp masks and leading-zero suppression.      |
// | Ports       : clk_i    - system clock                                      |
// |               rst_ni   - asynchronous active-low reset                     |
// |               we_i     - write strobe                                      |
// |               re_i     - read strobe                                       |
// |               addr_i   - byte address (DATA=BASE_ADDR, CTRL=BASE_ADDR+4)   |
// |               data_i   - write data                                        |
// |               rdata_o  - registered read data                              |
// |               an_o     - one-hot digit select, active-high                 |
// |               seg_o    - segments {a,b,c,d,e,f,g,dp}, active-high          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module dig_scan
  import dig_scan_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 8,
  parameter int unsigned SLOT_CYCLES = 20000,
  parameter logic [31:0] BASE_ADDR   = `PERI_ADDR_DIG
)(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  we_i,
  input  logic                  re_i,
  input  logic [31:0]           addr_i,
  input  logic [31:0]           data_i,
  output logic [31:0]           rdata_o,
  output logic [NUM_DIGITS-1:0] an_o,
  output logic [7:0]            seg_o
);

  // The slot prescaler is kept as (phase, cycle-within-phase) so the PWM
  // phase is available directly without a divider.
  localparam int unsigned c_phase_len  = SLOT_CYCLES / 16;
  localparam int unsigned c_pw         = (c_phase_len > 1) ? $clog2(c_phase_len) : 1;
  localparam int unsigned c_iw         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [c_pw-1:0] c_sub_last = c_pw'(c_phase_len - 1);
  localparam logic [c_iw-1:0] c_idx_last = c_iw'(NUM_DIGITS - 1);

  logic [c_pw-1:0]       r_sub;
  logic [3:0]            r_phase;
  logic [c_iw-1:0]       r_idx;
  logic [31:0]           r_shadow;
  logic [31:0]           r_active;
  logic [31:0]           r_ctrl;
  logic [31:0]           r_rdata;
  logic [NUM_DIGITS-1:0] r_an;
  logic [7:0]            r_seg;

  logic                  w_slot_end;
  logic                  w_frame_end;
  logic                  w_wr_data;
  logic                  w_wr_ctrl;
  logic                  w_rd_data;
  logic                  w_rd_ctrl;
  ctrl_t                 w_ctrl;
  logic [2:0]            w_sel;
  logic [3:0]            w_nib;
  logic [6:0]            w_seg7;
  logic                  w_upper_zero;
  logic                  w_lit;
  logic [NUM_DIGITS-1:0] w_an_next;
  logic [7:0]            w_seg_next;
  logic                  w_unused;

  assign w_slot_end  = (r_sub == c_sub_last) && (r_phase == 4'hF);
  assign w_frame_end = w_slot_end && (r_idx == c_idx_last);

  assign w_wr_data = we_i && (addr_i == BASE_ADDR + c_data_ofs);
  assign w_wr_ctrl = we_i && (addr_i == BASE_ADDR + c_ctrl_ofs);
  assign w_rd_data = re_i && (addr_i == BASE_ADDR + c_data_ofs);
  assign w_rd_ctrl = re_i && (addr_i == BASE_ADDR + c_ctrl_ofs);

  assign w_ctrl = ctrl_t'(r_ctrl);
  assign w_sel  = 3'(r_idx);
  assign w_nib  = r_active[{w_sel, 2'b00} +: 4];

  // Nibbles beyond NUM_DIGITS and reserved CTRL bits never reach the display.
  assign w_unused = ^{r_active, w_ctrl};

  // ---------------------------------------------------------------- scanning
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sub   <= '0;
      r_phase <= '0;
      r_idx   <= '0;
    end else begin
      if (r_sub == c_sub_last) begin
        r_sub   <= '0;
        r_phase <= r_phase + 4'd1;
      end else begin
        r_sub   <= r_sub + c_pw'(1);
      end
      if (w_slot_end) begin
        r_idx <= (r_idx == c_idx_last) ? '0 : r_idx + c_iw'(1);
      end
    end
  end

  // --------------------------------------------------------------- registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_shadow <= '0;
      r_active <= '0;
      r_ctrl   <= c_ctrl_rst;
      r_rdata  <= '0;
    end else begin
      if (w_wr_data) begin
        r_shadow <= data_i;
      end
      // A write landing on the boundary cycle bypasses the shadow so it is
      // not lost for a whole frame.
      if (w_frame_end) begin
        r_active <= w_wr_data ? data_i : r_shadow;
      end
      if (w_wr_ctrl) begin
        r_ctrl <= data_i & c_ctrl_wmask;
      end
      if (w_rd_data) begin
        r_rdata <= r_shadow;
      end else if (w_rd_ctrl) begin
        r_rdata <= r_ctrl;
      end else begin
        r_rdata <= '0;
      end
    end
  end

  // ------------------------------------------------------------ display path
  seg_decode u_seg_decode (
    .hex_i (w_nib),
    .seg_o (w_seg7)
  );

  // All active nibbles from the current digit upward are zero.
  always_comb begin
    w_upper_zero = 1'b1;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if ((i >= int'(w_sel)) && (r_active[4*i +: 4] != 4'h0)) begin
        w_upper_zero = 1'b0;
      end
    end
  end

  always_comb begin
    w_lit = w_ctrl.en
            && w_ctrl.dig_mask[w_sel]
            && (r_phase <= w_ctrl.bright)
            && !(w_ctrl.lzs && (w_sel != 3'd0) && w_upper_zero);
    w_an_next = '0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      w_an_next[i] = w_lit && (w_sel == 3'(i));
    end
    w_seg_next = w_lit ? {w_seg7, w_ctrl.dp_mask[w_sel]} : 8'h00;
  end

  // Registered outputs keep slot transitions glitch-free.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_an  <= '0;
      r_seg <= '0;
    end else begin
      r_an  <= w_an_next;
      r_seg <= w_seg_next;
    end
  end

  assign rdata_o = r_rdata;
  assign an_o    = r_an;
  assign seg_o   = r_seg;

endmodule

`default_nettype wire

// File: tb/tb_dig_scan.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_dig_scan                                                  |
// | Description : Self-checking bench for dig_scan. Two instances share one    |
// |               register bus: 8 digits x 32-cycle slots and 4 digits x       |
// |               16-cycle slots. A cycle-count based model predicts every     |
// |               output; directed steps add hand-computed expectations.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_dig_scan;

  localparam logic [31:0] A_DATA = 32'h4000_0100;
  localparam logic [31:0] A_CTRL = 32'h4000_0104;

  localparam logic [7:0] SEG_TBL [16] = '{
    8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
    8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E
  };

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        we    = 1'b0;
  logic        re    = 1'b0;
  logic [31:0] addr  = 32'd0;
  logic [31:0] wdata = 32'd0;

  logic [31:0] rdata8, rdata4;
  logic [7:0]  an8;
  logic [3:0]  an4;
  logic [7:0]  seg8, seg4;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  dig_scan #(.NUM_DIGITS(8), .SLOT_CYCLES(32), .BASE_ADDR(A_DATA)) u_dut8 (
    .clk_i(clk), .rst_ni(rst_n), .we_i(we), .re_i(re), .addr_i(addr),
    .data_i(wdata), .rdata_o(rdata8), .an_o(an8), .seg_o(seg8)
  );

  dig_scan #(.NUM_DIGITS(4), .SLOT_CYCLES(16), .BASE_ADDR(A_DATA)) u_dut4 (
    .clk_i(clk), .rst_ni(rst_n), .we_i(we), .re_i(re), .addr_i(addr),
    .data_i(wdata), .rdata_o(rdata4), .an_o(an4), .seg_o(seg4)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------ model
  // State is the number of clock edges since reset release plus the three
  // architectural registers; the display position follows by arithmetic.
  int          nd [2] = '{8, 4};
  int          sc [2] = '{32, 16};
  int          k  [2] = '{0, 0};
  logic [31:0] m_shadow [2] = '{0, 0};
  logic [31:0] m_active [2] = '{0, 0};
  logic [31:0] m_ctrl   [2] = '{32'h0F00FF01, 32'h0F00FF01};
  logic [31:0] m_rdata  [2] = '{0, 0};
  logic [7:0]  m_an     [2] = '{0, 0};
  logic [7:0]  m_seg    [2] = '{0, 0};

  function automatic void calc_out(input int n, input int s, input int kk,
                                   input logic [31:0] act, input logic [31:0] ctl,
                                   output logic [7:0] an, output logic [7:0] seg);
    int pos, idx, ph;
    bit upper_zero;
    logic [3:0] nib;
    pos = kk % (n * s);
    idx = pos / s;
    ph  = (pos % s) / (s / 16);
    nib = act[4*idx +: 4];
    upper_zero = 1'b1;
    for (int j = idx; j < n; j++) if (act[4*j +: 4] != 4'h0) upper_zero = 1'b0;
    an  = 8'h00;
    seg = 8'h00;
    if (ctl[0] && ctl[8+idx] && (ph <= int'(ctl[27:24]))
        && !(ctl[1] && idx > 0 && upper_zero)) begin
      an  = 8'h01 << idx;
      seg = SEG_TBL[nib] | {7'd0, ctl[16+idx]};
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        k[d] = 0; m_shadow[d] = 0; m_active[d] = 0; m_ctrl[d] = 32'h0F00FF01;
        m_rdata[d] = 0; m_an[d] = 0; m_seg[d] = 0;
      end else begin
        calc_out(nd[d], sc[d], k[d], m_active[d], m_ctrl[d], m_an[d], m_seg[d]);
        if (re && addr == A_DATA)      m_rdata[d] = m_shadow[d];
        else if (re && addr == A_CTRL) m_rdata[d] = m_ctrl[d];
        else                           m_rdata[d] = 0;
        if (we && addr == A_DATA) m_shadow[d] = wdata;
        if ((k[d] % (nd[d] * sc[d])) == nd[d] * sc[d] - 1) m_active[d] = m_shadow[d];
        if (we && addr == A_CTRL) m_ctrl[d] = wdata & 32'h0FFFFF03;
        k[d]++;
      end
    end
  end

  always @(negedge clk) begin
    chk("rdata8", rdata8, m_rdata[0]);
    chk("an8",    {24'd0, an8}, {24'd0, m_an[0]});
    chk("seg8",   {24'd0, seg8}, {24'd0, m_seg[0]});
    chk("rdata4", rdata4, m_rdata[1]);
    chk("an4",    {28'd0, an4}, {24'd0, m_an[1]});
    chk("seg4",   {24'd0, seg4}, {24'd0, m_seg[1]});
  end

  // -------------------------------------------------------------- stimulus
  // All drives happen 2 time units after a rising edge.
  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wdata = d;
    cycles(1);
    we = 1'b0; addr = 32'd0; wdata = 32'd0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    re = 1'b1; addr = a;
    cycles(1);
    re = 1'b0; addr = 32'd0;
    v = rdata8;
  endtask

  task automatic wait_an8(input logic [7:0] want, input string nm);
    int i;
    i = 0;
    while (an8 !== want && i < 600) begin cycles(1); i++; end
    chk(nm, {24'd0, an8}, {24'd0, want});
  endtask

  task automatic count_lit(input int n, output int c8, output int c4, output int c8hi);
    c8 = 0; c4 = 0; c8hi = 0;
    repeat (n) begin
      if (an8 != 8'h00) c8++;
      if (an4 != 4'h0)  c4++;
      if (an8[7:2] != 6'd0 || (an8 != 8'h00 && an8 != 8'h01 && an8 != 8'h02)) c8hi++;
      cycles(1);
    end
  endtask

  initial begin
    logic [31:0] v;
    int c8, c4, chi, guard;

    // Reset state
    cycles(3);
    chk("rst_an8", {24'd0, an8}, 32'd0);
    chk("rst_seg8", {24'd0, seg8}, 32'd0);
    chk("rst_rdata", rdata8, 32'd0);
    rst_n = 1'b1;
    rd(A_CTRL, v); chk("ctrl_rst", v, 32'h0F00FF01);
    rd(A_DATA, v); chk("data_rst", v, 32'h0);

    // Basic display
    wr(A_DATA, 32'h89ABCDEF);
    cycles(512);
    wait_an8(8'h80, "d7_seen");   chk("d7_seg", {24'd0, seg8}, 32'hFE);
    wait_an8(8'h01, "d0_seen");   chk("d0_seg", {24'd0, seg8}, 32'h8E);

    // Mid-frame write: old value until the boundary
    wait_an8(8'h08, "d3_seen");
    wr(A_DATA, 32'h00000012);
    rd(A_DATA, v); chk("shadow_rb", v, 32'h00000012);
    wait_an8(8'h80, "d7_old_seen"); chk("d7_old_seg", {24'd0, seg8}, 32'hFE);
    wait_an8(8'h01, "d0_new_seen"); chk("d0_new_seg", {24'd0, seg8}, 32'hDA);
    wait_an8(8'h02, "d1_new_seen"); chk("d1_new_seg", {24'd0, seg8}, 32'h60);

    // Leading-zero suppression
    wr(A_CTRL, 32'h0F00FF03);
    cycles(3);
    count_lit(256, c8, c4, chi);
    chk("lzs_lit_cycles", c8, 64);
    chk("lzs_hi_dark", chi, 0);
    wr(A_DATA, 32'h0);
    cycles(512);
    wait_an8(8'h01, "lzs0_seen"); chk("lzs0_seg", {24'd0, seg8}, 32'hFC);
    count_lit(256, c8, c4, chi);
    chk("lzs0_lit_cycles", c8, 32);

    // Brightness
    wr(A_CTRL, 32'h0300FF01);
    cycles(3);
    count_lit(256, c8, c4, chi);
    chk("bright3_n8", c8, 64);
    chk("bright3_n4", c4, 64);
    wr(A_CTRL, 32'h0000FF01);
    cycles(3);
    count_lit(256, c8, c4, chi);
    chk("bright0_n8", c8, 16);
    chk("bright0_n4", c4, 16);

    // Digit mask and decimal points (model-checked), then EN=0
    wr(A_CTRL, 32'h0F81A501);
    wr(A_DATA, 32'h89ABCDEF);
    cycles(600);
    wr(A_CTRL, 32'h0F00FF00);
    cycles(3);
    count_lit(256, c8, c4, chi);
    chk("en0_n8", c8, 0);
    chk("en0_n4", c4, 0);

    // Write on the frame-boundary cycle of the 4-digit instance
    wr(A_CTRL, 32'h0F00FF01);
    wr(A_DATA, 32'h0);
    cycles(300);
    guard = 0;
    while ((k[1] % 64) != 63 && guard < 100) begin cycles(1); guard++; end
    chk("bnd_sync", {31'd0, guard < 100}, 32'd1);
    wr(A_DATA, 32'h00004321);
    chk("bnd_old_an4", {28'd0, an4}, 32'h8);
    chk("bnd_old_seg4", {24'd0, seg4}, 32'hFC);
    cycles(1);
    chk("bnd_new_an4", {28'd0, an4}, 32'h1);
    chk("bnd_new_seg4", {24'd0, seg4}, 32'h60);

    // Asynchronous reset while lit
    cycles(5);
    rst_n = 1'b0;
    #1;
    chk("arst_an8", {24'd0, an8}, 32'd0);
    chk("arst_seg8", {24'd0, seg8}, 32'd0);
    chk("arst_an4", {28'd0, an4}, 32'd0);
    cycles(2);
    rst_n = 1'b1;
    rd(A_CTRL, v); chk("ctrl_after_rst", v, 32'h0F00FF01);
    rd(A_DATA, v); chk("data_after_rst", v, 32'h0);
    cycles(40);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
